// File: rtl/if_id_stage_pkg.sv
// Shared definitions for the fetch stage and IF/ID register: bubble word,
// FSM encodings, reset PC sentinel and the IF/ID payload.
package if_id_stage_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] IF_NOP_INST    = 32'h0000_0013;
    localparam logic [XLEN-1:0] IF_PC_SENTINEL = 32'hffff_fffc;

    typedef enum logic [1:0] {
        IF_BOOT = 2'd0,
        IF_RUN  = 2'd1,
        IF_HALT = 2'd2
    } if_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] instr;
        logic            valid;
    } ifid_t;

    // Redirect targets are word aligned by clearing the low two bits.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_pc_reg.sv
// Program counter register: redirect wins, otherwise hold or step by 4 (mod 2^32).
module if_pc_reg
    import if_id_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_target,
    input  logic            i_hold,
    output logic [XLEN-1:0] o_pc
);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_nxt;

    always_comb begin
        w_pc_nxt = r_pc;
        if (i_redirect) begin
            w_pc_nxt = align_pc(i_target);
        end else if (!i_hold) begin
            w_pc_nxt = r_pc + XLEN'(4);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_nxt;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/if_id_stage.sv
// Fetch stage with IF/ID register and BOOT/RUN/HALT control.
// Optional stall/flush performance counters under IF_PERF_CNT_EN.
module if_id_stage
    import if_id_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = IF_NOP_INST
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] irom_addr,
    input  logic [31:0] irom_data,
    input  logic        stall,
    input  logic        redirect_EX,
    input  logic [31:0] redirect_target_EX,
    input  logic        halt_req,
    input  logic        resume,
    output logic [31:0] ID_PC,
    output logic [31:0] ID_pc4,
    output logic [31:0] ID_instruction,
    output logic        ID_valid,
    output logic        halted
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    if_state_e r_state;
    if_state_e w_state_nxt;
    ifid_t     r_ifid;
    logic [XLEN-1:0] w_pc;
    logic      w_pc_redirect;
    logic      w_pc_hold;
    logic      w_ifid_load;
    logic      w_ifid_bubble;

    if_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_redirect (w_pc_redirect),
        .i_target   (redirect_target_EX),
        .i_hold     (w_pc_hold),
        .o_pc       (w_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IF_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and per-cycle PC / IF/ID control, redirect highest in RUN.
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_redirect = 1'b0;
        w_pc_hold     = 1'b1;
        w_ifid_load   = 1'b0;
        w_ifid_bubble = 1'b0;
        case (r_state)
            IF_BOOT: begin
                w_ifid_bubble = 1'b1;
                w_state_nxt   = halt_req ? IF_HALT : IF_RUN;
            end
            IF_RUN: begin
                if (redirect_EX) begin
                    w_pc_redirect = 1'b1;
                    w_ifid_bubble = 1'b1;
                end else if (halt_req) begin
                    w_state_nxt   = IF_HALT;
                    w_ifid_bubble = 1'b1;
                end else if (!stall) begin
                    w_pc_hold   = 1'b0;
                    w_ifid_load = 1'b1;
                end
            end
            IF_HALT: begin
                w_ifid_bubble = 1'b1;
                w_pc_redirect = redirect_EX;
                if (resume && !halt_req) begin
                    w_state_nxt = IF_RUN;
                end
            end
            default: begin
                w_state_nxt = IF_BOOT;
            end
        endcase
    end

    // A bubble keeps ID_PC/ID_pc4 and only kills the instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ifid <= '{pc: IF_PC_SENTINEL, pc4: '0, instr: NOP_INST, valid: 1'b0};
        end else if (w_ifid_load) begin
            r_ifid <= '{pc: w_pc, pc4: w_pc + XLEN'(4), instr: irom_data, valid: 1'b1};
        end else if (w_ifid_bubble) begin
            r_ifid.instr <= NOP_INST;
            r_ifid.valid <= 1'b0;
        end
    end

    assign irom_addr      = w_pc;
    assign ID_PC          = r_ifid.pc;
    assign ID_pc4         = r_ifid.pc4;
    assign ID_instruction = r_ifid.instr;
    assign ID_valid       = r_ifid.valid;
    assign halted         = (r_state == IF_HALT);

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;
    logic        w_stall_evt;
    logic        w_flush_evt;

    assign w_stall_evt = (r_state == IF_RUN) && stall && !redirect_EX;
    assign w_flush_evt = ((r_state == IF_RUN) || (r_state == IF_HALT)) && redirect_EX;

    // Saturating event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_evt && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_flush_evt && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = r_stall_cnt;
    assign perf_flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: cycle scoreboard plus directed spot checks.
module tb_if_id_stage;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] idpc;
        logic [31:0] pc4;
        logic [31:0] inst;
        logic        valid;
        logic        halted;
        logic [31:0] scnt;
        logic [31:0] fcnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] irom_addr;
    logic [31:0] irom_data;
    logic        stall = 1'b0;
    logic        redirect_EX = 1'b0;
    logic [31:0] redirect_target_EX = 32'h0;
    logic        halt_req = 1'b0;
    logic        resume = 1'b0;
    logic [31:0] ID_PC;
    logic [31:0] ID_pc4;
    logic [31:0] ID_instruction;
    logic        ID_valid;
    logic        halted;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;
    exp_t sb_q[$];

    // Reference model state
    int          m_st;
    logic [31:0] m_pc, m_idpc, m_pc4, m_inst, m_scnt, m_fcnt;
    logic        m_valid;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return {8'hA5, a[23:0]};
    endfunction

    assign irom_data = rom(irom_addr);

    always #5 clk = ~clk;

    if_id_stage dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .irom_addr          (irom_addr),
        .irom_data          (irom_data),
        .stall              (stall),
        .redirect_EX        (redirect_EX),
        .redirect_target_EX (redirect_target_EX),
        .halt_req           (halt_req),
        .resume             (resume),
        .ID_PC              (ID_PC),
        .ID_pc4             (ID_pc4),
        .ID_instruction     (ID_instruction),
        .ID_valid           (ID_valid),
        .halted             (halted)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_stall_cnt     (perf_stall_cnt),
        .perf_flush_cnt     (perf_flush_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_pc = 32'h0; m_idpc = 32'hffff_fffc; m_pc4 = 32'h0;
        m_inst = 32'h0000_0013; m_valid = 1'b0; m_scnt = 32'h0; m_fcnt = 32'h0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_addr"},  irom_addr, 32'h0);
        check({tag, "_idpc"},  ID_PC, 32'hffff_fffc);
        check({tag, "_pc4"},   ID_pc4, 32'h0);
        check({tag, "_inst"},  ID_instruction, 32'h0000_0013);
        check({tag, "_valid"}, 32'(ID_valid), 32'h0);
        check({tag, "_halt"},  32'(halted), 32'h0);
`ifdef IF_PERF_CNT_EN
        check({tag, "_scnt"},  perf_stall_cnt, 32'h0);
        check({tag, "_fcnt"},  perf_flush_cnt, 32'h0);
`endif
    endtask

    // Predict the post-edge outputs from current inputs, clock, then compare.
    task automatic step();
        exp_t e;
        logic bubble;
        bubble = 1'b0;
        if (m_st == 0) begin
            bubble = 1'b1;
            m_st = halt_req ? 2 : 1;
        end else if (m_st == 1) begin
            if (redirect_EX) begin
                m_pc = redirect_target_EX & 32'hffff_fffc;
                bubble = 1'b1;
                m_fcnt = m_fcnt + 32'd1;
            end else if (halt_req) begin
                m_st = 2;
                bubble = 1'b1;
            end else if (stall) begin
                m_scnt = m_scnt + 32'd1;
            end else begin
                m_idpc = m_pc; m_pc4 = m_pc + 32'd4; m_inst = rom(m_pc);
                m_valid = 1'b1; m_pc = m_pc + 32'd4;
            end
        end else begin
            bubble = 1'b1;
            if (redirect_EX) begin
                m_pc = redirect_target_EX & 32'hffff_fffc;
                m_fcnt = m_fcnt + 32'd1;
            end
            if (resume && !halt_req) m_st = 1;
        end
        if (bubble) begin
            m_inst = 32'h0000_0013;
            m_valid = 1'b0;
        end
        e = '{addr: m_pc, idpc: m_idpc, pc4: m_pc4, inst: m_inst, valid: m_valid,
              halted: (m_st == 2), scnt: m_scnt, fcnt: m_fcnt};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_empty: got 0 entries expected 1");
        end else begin
            e = sb_q.pop_front();
            check("irom_addr", irom_addr, e.addr);
            check("ID_PC", ID_PC, e.idpc);
            check("ID_pc4", ID_pc4, e.pc4);
            check("ID_instruction", ID_instruction, e.inst);
            check("ID_valid", 32'(ID_valid), 32'(e.valid));
            check("halted", 32'(halted), 32'(e.halted));
`ifdef IF_PERF_CNT_EN
            check("perf_stall_cnt", perf_stall_cnt, e.scnt);
            check("perf_flush_cnt", perf_flush_cnt, e.fcnt);
`endif
        end
    endtask

    task automatic set_in(input logic s, input logic r, input logic [31:0] t,
                          input logic h, input logic rs);
        stall = s; redirect_EX = r; redirect_target_EX = t; halt_req = h; resume = rs;
    endtask

    initial begin
        model_reset();
        #12;
        check_reset_values("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Boot bubble, then sequential fetch 0, 4, 8, 0xC
        step();
        check("boot_valid", 32'(ID_valid), 32'h0);
        step();
        check("first_valid", 32'(ID_valid), 32'h1);
        check("first_pc", ID_PC, 32'h0);
        check("first_inst", ID_instruction, 32'hA500_0000);
        step();
        check("seq_pc4", ID_PC, 32'h4);
        step();
        check("seq_pc8", ID_PC, 32'h8);
        step();

        // Stall for three cycles at pc 0x10
        set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        repeat (3) begin
            step();
            check("stall_idpc", ID_PC, 32'hC);
            check("stall_addr", irom_addr, 32'h10);
        end
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step();
        check("unstall_pc", ID_PC, 32'h10);

        // Misaligned redirect overriding stall
        set_in(1'b1, 1'b1, 32'h103, 1'b0, 1'b0);
        step();
        check("redir_addr", irom_addr, 32'h100);
        check("redir_bubble", 32'(ID_valid), 32'h0);
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step();
        check("redir_fetch", ID_PC, 32'h100);

        // Halt at 0x20, redirect to 0x40 while halted, then resume
        set_in(1'b0, 1'b1, 32'h20, 1'b0, 1'b0);
        step();
        set_in(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        step();
        check("halt_entered", 32'(halted), 32'h1);
        check("halt_addr", irom_addr, 32'h20);
        set_in(1'b0, 1'b1, 32'h40, 1'b1, 1'b0);
        step();
        set_in(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        step();
        check("resume_held", 32'(halted), 32'h1);
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        step();
        check("resume_bubble", 32'(ID_valid), 32'h0);
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step();
        check("resume_pc", ID_PC, 32'h40);
        check("resume_valid", 32'(ID_valid), 32'h1);

        // PC wrap at the top of the address space
        set_in(1'b0, 1'b1, 32'hffff_fffc, 1'b0, 1'b0);
        step();
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step();
        check("wrap_addr", irom_addr, 32'h0);
        check("wrap_pc4", ID_pc4, 32'h0);

        // Random mix checked through the scoreboard
        for (int i = 0; i < 60; i++) begin
            set_in(($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0), $urandom(),
                   ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0));
            step();
        end

        // Asynchronous reset while halted
        set_in(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        step();
        step();
        check("pre_reset_halt", 32'(halted), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        model_reset();
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step();
        step();
        check("post_reset_pc", ID_PC, 32'h0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
